// File: rtl/matrix_op_controller.sv
// Sequencer for the matrix coprocessor: loads N, A and B from single-port RAM,
// streams element pairs through a handshaked ALU and writes C back in order.
module matrix_op_controller #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 8,
   parameter int MAX_DIM = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        opcode,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_op,
   output logic              alu_valid,
   input  logic              alu_done,
   input  logic [DATA_W-1:0] alu_result
);

   localparam int CW    = ADDR_W + 2;
   localparam int DEPTH = MAX_DIM * MAX_DIM;
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [DATA_W-1:0] MAX_N = DATA_W'(MAX_DIM);

   typedef enum logic [2:0] {
      IDLE, RD_SIZE, CHECK, LOAD, ISSUE, WAIT_DONE, WRITE, FINISH
   } state_t;

   state_t state, state_d;

   logic [DATA_W-1:0] n_q, n_d;
   logic [2:0]        op_q, op_d;
   logic [CW-1:0]     k, k_d;
   logic [CW-1:0]     rd_addr, rd_d;
   logic [CW-1:0]     cap_addr, cap_addr_d;
   logic              cap_vld, cap_vld_d;
   logic              rd_wait, rd_wait_d;
   logic              busy_d, done_d, error_d, we_d, valid_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d, a_d, b_d;
   logic [2:0]        alu_op_d;

   logic [DATA_W-1:0] buf_a [0:DEPTH-1];
   logic [DATA_W-1:0] buf_b [0:DEPTH-1];

   logic [CW-1:0] nn, two_nn;
   assign nn     = CW'(n_q) * CW'(n_q);
   assign two_nn = nn + nn;

   always_comb begin
      state_d    = state;
      n_d        = n_q;
      op_d       = op_q;
      k_d        = k;
      rd_d       = rd_addr;
      cap_addr_d = cap_addr;
      cap_vld_d  = 1'b0;
      rd_wait_d  = rd_wait;
      busy_d     = busy;
      done_d     = 1'b0;
      error_d    = error;
      we_d       = 1'b0;
      valid_d    = alu_valid;
      addr_d     = mem_addr;
      wdata_d    = mem_wdata;
      a_d        = alu_a;
      b_d        = alu_b;
      alu_op_d   = alu_op;
      case (state)
         IDLE: begin
            if (start) begin
               op_d      = opcode;
               busy_d    = 1'b1;
               error_d   = 1'b0;
               addr_d    = '0;
               rd_wait_d = 1'b0;
               state_d   = RD_SIZE;
            end
         end
         RD_SIZE: begin
            // first cycle presents addr 0, second cycle sees its data
            if (!rd_wait) rd_wait_d = 1'b1;
            else begin
               n_d     = mem_rdata;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (n_q == '0 || n_q > MAX_N || op_q == 3'b111) begin
               error_d = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = FINISH;
            end else begin
               rd_d    = CW'(1);
               addr_d  = ADDR_W'(1);
               k_d     = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            // cap_* trails the presented address by one cycle (RAM read latency)
            cap_vld_d  = (rd_addr <= two_nn);
            cap_addr_d = rd_addr;
            if (rd_addr < two_nn) begin
               rd_d   = rd_addr + CW'(1);
               addr_d = ADDR_W'(rd_addr + CW'(1));
            end
            if (cap_vld && cap_addr == two_nn) begin
               cap_vld_d = 1'b0;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            a_d      = buf_a[IW'(k)];
            b_d      = buf_b[IW'(k)];
            alu_op_d = op_q;
            valid_d  = 1'b1;
            state_d  = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (alu_done) begin
               valid_d = 1'b0;
               wdata_d = alu_result;
               we_d    = 1'b1;
               addr_d  = ADDR_W'(two_nn + CW'(1) + k);
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (k == nn - CW'(1)) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = FINISH;
            end else begin
               k_d     = k + CW'(1);
               state_d = ISSUE;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         n_q       <= '0;
         op_q      <= '0;
         k         <= '0;
         rd_addr   <= '0;
         cap_addr  <= '0;
         cap_vld   <= 1'b0;
         rd_wait   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         mem_we    <= 1'b0;
         alu_valid <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
      end else begin
         state     <= state_d;
         n_q       <= n_d;
         op_q      <= op_d;
         k         <= k_d;
         rd_addr   <= rd_d;
         cap_addr  <= cap_addr_d;
         cap_vld   <= cap_vld_d;
         rd_wait   <= rd_wait_d;
         busy      <= busy_d;
         done      <= done_d;
         error     <= error_d;
         mem_we    <= we_d;
         alu_valid <= valid_d;
         mem_addr  <= addr_d;
         mem_wdata <= wdata_d;
         alu_a     <= a_d;
         alu_b     <= b_d;
         alu_op    <= alu_op_d;
      end
   end

   // operand buffers need no reset: always fully loaded before use
   always_ff @(posedge clk) begin
      if (state == LOAD && cap_vld) begin
         if (cap_addr <= nn) buf_a[IW'(cap_addr - CW'(1))] <= mem_rdata;
         else                buf_b[IW'(cap_addr - nn - CW'(1))] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_matrix_op_controller.sv
// Bench for matrix_op_controller: behavioural RAM and ALU, a table of operations
// with expected outcomes, plus hand sequences for mid-op reset and held start.
module tb_matrix_op_controller;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [2:0] opcode;
   logic       busy, done, error, mem_we, alu_valid, alu_done;
   logic [7:0] mem_addr, mem_wdata, mem_rdata, alu_a, alu_b, alu_result;
   logic [2:0] alu_op;

   always #5 clk = ~clk;

   matrix_op_controller #(.DATA_W(8), .ADDR_W(8), .MAX_DIM(5)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode),
      .busy(busy), .done(done), .error(error),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_valid(alu_valid),
      .alu_done(alu_done), .alu_result(alu_result)
   );

   localparam logic [7:0] SENT = 8'hEE;

   function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'(a) * 16'(b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return p[7:0];
         3'd6: return (a > b) ? a : b;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] fa(input int i); return 8'(i + 1); endfunction
   function automatic logic [7:0] fb(input int i); return 8'(10 * (i + 1)); endfunction

   // RAM: synchronous read, DUT write has priority over the bench preload port
   logic [7:0] ram [0:255];
   logic       tb_we = 1'b0;
   logic [7:0] tb_addr = 8'h00, tb_data = 8'h00;
   always @(posedge clk) begin
      if (mem_we)     ram[mem_addr] <= mem_wdata;
      else if (tb_we) ram[tb_addr]  <= tb_data;
      mem_rdata <= ram[mem_addr];
   end

   // ALU: answers `lat` cycles after operands become valid
   bit rand_lat  = 1'b0;
   int fixed_lat = 1;
   int cnt, lat;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_done   <= 1'b0;
         alu_result <= 8'h00;
         cnt        <= 0;
         lat        <= 1;
      end else begin
         alu_done <= 1'b0;
         if (alu_valid && !alu_done) begin
            if (cnt >= (rand_lat ? lat : fixed_lat) - 1) begin
               alu_done   <= 1'b1;
               alu_result <= ref_alu(alu_op, alu_a, alu_b);
               cnt        <= 0;
               lat        <= int'($urandom_range(1, 6));
            end else cnt <= cnt + 1;
         end else cnt <= 0;
      end
   end

   int we_cnt = 0, done_cnt = 0, strobe_cnt = 0, stab_err = 0;
   logic pv = 1'b0;
   logic [7:0] pa = 8'h00, pb = 8'h00;
   always @(negedge clk) begin
      if (mem_we) we_cnt <= we_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (alu_valid && !pv) strobe_cnt <= strobe_cnt + 1;
      if (alu_valid && pv && (alu_a != pa || alu_b != pb)) stab_err <= stab_err + 1;
      pv <= alu_valid;
      pa <= alu_a;
      pb <= alu_b;
   end

   int pass_cnt = 0, total = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic ram_wr(input int a, input int d);
      tb_we = 1'b1; tb_addr = 8'(a); tb_data = 8'(d);
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic prep(input int n);
      for (int a = 1; a <= 80; a++) ram_wr(a, SENT);
      ram_wr(0, n);
      if (n >= 1 && n <= 5)
         for (int i = 0; i < n * n; i++) begin
            ram_wr(1 + i, fa(i));
            ram_wr(1 + n * n + i, fb(i));
         end
   endtask

   task automatic wait_done(input int maxc, output bit ok, output int busy_lo);
      ok = 1'b0; busy_lo = 0;
      for (int c = 0; c < maxc; c++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
         if (!busy) busy_lo++;
      end
   endtask

   typedef struct {
      int n; int op; bit rnd; int exp_err;
   } vec_t;

   task automatic run_op(input vec_t v);
      int b_we, b_dn, b_st, nn, blo;
      bit ok;
      rand_lat = v.rnd; fixed_lat = 1;
      prep(v.n);
      nn = v.n * v.n;
      b_we = we_cnt; b_dn = done_cnt; b_st = strobe_cnt;
      opcode = 3'(v.op); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("accept_busy", int'(busy), 1);
      check("error_cleared", int'(error), 0);
      wait_done(3000, ok, blo);
      check("done_seen", int'(ok), 1);
      check("busy_held", blo, 0);
      check("error_flag", int'(error), v.exp_err);
      @(negedge clk);
      check("done_once", done_cnt - b_dn, 1);
      check("we_pulses", we_cnt - b_we, v.exp_err != 0 ? 0 : nn);
      check("alu_strobes", strobe_cnt - b_st, v.exp_err != 0 ? 0 : nn);
      if (v.exp_err == 0) begin
         for (int i = 0; i < nn; i++)
            check($sformatf("c[%0d]", 2 * nn + 1 + i), int'(ram[2 * nn + 1 + i]),
                  int'(ref_alu(3'(v.op), fa(i), fb(i))));
         check("no_write_past_c", int'(ram[3 * nn + 1]), int'(SENT));
      end
   endtask

   vec_t vt [9];
   int   hand_c [4];

   initial begin
      int b_we, b_dn, untouched, blo;
      bit ok;
      vt[0] = '{2, 0, 1'b0, 0};
      vt[1] = '{5, 1, 1'b1, 0};
      vt[2] = '{0, 0, 1'b0, 1};
      vt[3] = '{6, 0, 1'b0, 1};
      vt[4] = '{4, 5, 1'b1, 0};
      vt[5] = '{3, 7, 1'b0, 1};
      vt[6] = '{1, 4, 1'b0, 0};
      vt[7] = '{5, 6, 1'b1, 0};
      vt[8] = '{3, 2, 1'b1, 0};
      hand_c = '{11, 22, 33, 44};

      rst = 1'b1; start = 1'b0; opcode = 3'd0;
      repeat (3) @(negedge clk);
      check("reset_outputs_zero",
            int'(|{busy, done, error, mem_we, alu_valid, mem_addr, mem_wdata, alu_a, alu_b, alu_op}), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         run_op(vt[i]);
         if (vt[i].n == 2 && vt[i].op == 0)
            for (int j = 0; j < 4; j++)
               check($sformatf("n2_add_c%0d", j), int'(ram[9 + j]), hand_c[j]);
      end
      check("operands_stable", stab_err, 0);

      // reset during the third ALU wait with N=3
      rand_lat = 1'b0; fixed_lat = 6;
      prep(3);
      for (int a = 19; a <= 27; a++) ram_wr(a, SENT);
      b_we = we_cnt;
      opcode = 3'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (strobe_cnt - (strobe_cnt - strobe_cnt) >= 0 && alu_valid && we_cnt - b_we == 2) begin
            ok = 1'b1; break;
         end
      end
      check("reached_third_wait", int'(ok), 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check("reset_mid_op_zero",
               int'(|{busy, done, error, mem_we, alu_valid, mem_addr, mem_wdata, alu_a, alu_b, alu_op}), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_we_count", we_cnt - b_we, 2);
      check("reset_c19", int'(ram[19]), 11);
      check("reset_c20", int'(ram[20]), 22);
      untouched = 0;
      for (int a = 21; a <= 27; a++) if (ram[a] == SENT) untouched++;
      check("reset_c21_27_untouched", untouched, 7);
      run_op('{3, 0, 1'b0, 0});

      // start held high across two operations
      rand_lat = 1'b0; fixed_lat = 1;
      prep(2);
      b_we = we_cnt; b_dn = done_cnt;
      opcode = 3'd0; start = 1'b1;
      wait_done(500, ok, blo);
      check("held_first_done", int'(ok), 1);
      @(negedge clk);
      check("held_idle_gap", int'(busy), 0);
      @(negedge clk);
      check("held_restart", int'(busy), 1);
      wait_done(500, ok, blo);
      check("held_second_done", int'(ok), 1);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("held_done_pulses", done_cnt - b_dn, 2);
      check("held_we_pulses", we_cnt - b_we, 8);
      check("held_idle_after", int'(busy), 0);
      check("held_c12", int'(ram[12]), 44);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total);
      $fatal(1);
   end

endmodule

// File: doc/matrix_op_controller.md
Name: matrix_op_controller

Overview:
- Sequencer for the matrix coprocessor.
- On `start` it reads the dimension word and the A and B operand matrices from the single-port RAM into local buffers.
- It then drives the element-wise matrix ALU one element at a time and writes each result back to RAM.
- It sits between the host/start logic, the ram1port instance and the element ALU, replacing free-running, clock-divided iteration with a handshaked schedule.

Parameters:
- DATA_W, 8, width of RAM words, matrix elements and ALU operands.
- ADDR_W, 8, RAM address width.
- MAX_DIM, 5, largest legal matrix dimension N; the buffers hold MAX_DIM*MAX_DIM elements.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin operation; sampled only in IDLE.
- opcode  in  3  ALU operation, latched at start; 3'b111 is illegal.
- busy  out  1  high from start acceptance until the done pulse.
- done  out  1  one-cycle completion pulse, on success or on error.
- error  out  1  set with done on illegal size/opcode; held until the next accepted start or reset.
- mem_addr  out  ADDR_W  RAM address, registered.
- mem_wdata  out  DATA_W  RAM write data, registered.
- mem_we  out  1  RAM write enable, registered.
- mem_rdata  in  DATA_W  RAM read data.
- alu_a  out  DATA_W  element of A.
- alu_b  out  DATA_W  element of B.
- alu_op  out  3  latched opcode.
- alu_valid  out  1  operand-valid strobe, held until alu_done.
- alu_done  in  1  ALU result valid, one-cycle pulse.
- alu_result  in  DATA_W  ALU result, sampled when alu_done=1.

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, error, mem_we and alu_valid are 0; mem_addr, mem_wdata, alu_a, alu_b and alu_op are 0.
  - Reset mid-operation aborts with no further RAM writes.
  - RAM contents already written are left as they are.
- RAM timing: read data for the address presented in cycle t is valid on mem_rdata in cycle t+1. Writes occur on the edge where mem_we=1.
- Memory map:
  - addr 0 = N.
  - addr 1..N*N = A, row-major.
  - addr N*N+1..2*N*N = B.
  - addr 2*N*N+1..3*N*N = results C.
- Address arithmetic is done at ADDR_W+2 bits. The 3*N*N upper bound with MAX_DIM=5 is 75, so there is no wrap.
- State IDLE:
  - start=1 latches opcode, sets busy=1, clears error, drives mem_addr=0, and goes to RD_SIZE.
  - start=0 stays in IDLE.
  - start while not in IDLE is ignored.
- State RD_SIZE: waits one cycle, then captures N from mem_rdata and goes to CHECK.
- State CHECK:
  - If N==0, N>MAX_DIM or opcode==3'b111, go to FINISH with error=1.
  - Otherwise go to LOAD.
- State LOAD:
  - Pipelined: presents addr 1..2*N*N on consecutive cycles, one per cycle.
  - Each data word is captured one cycle later.
  - Words for addr <= N*N go to bufA[addr-1]; the rest go to bufB[addr-N*N-1].
  - After the last capture, go to ISSUE with k=0.
- State ISSUE:
  - Drives alu_a=bufA[k], alu_b=bufB[k], alu_op=opcode, alu_valid=1, then goes to WAIT.
- State WAIT:
  - alu_valid and the operands stay stable.
  - On alu_done=1, drop alu_valid, latch alu_result and go to WRITE.
  - An alu_done arriving in the same cycle alu_valid first rises is accepted.
  - alu_done while not in WAIT is ignored.
  - There is no timeout.
- State WRITE:
  - One cycle with mem_addr=2*N*N+1+k, mem_wdata=result, mem_we=1.
  - If k==N*N-1, go to FINISH; else k=k+1 and go to ISSUE.
- State FINISH: done=1 for one cycle, busy=0, mem_we=0, then go to IDLE.
  - start in the FINISH cycle is ignored.
  - start in the following cycle is accepted.
- mem_we is high only in WRITE; RAM is never written in any other state.
- Each result is written exactly once, in increasing address order.

Test Plan:
- N=2, A={1,2,3,4}, B={10,20,30,40}, opcode=000 (add), ALU responding 1 cycle after valid -> RAM[9..12]={11,22,33,44}; exactly 4 mem_we pulses; one done pulse; error=0; busy high through the op.
- N=5, full 25-element A and B, ALU latency varied randomly 1..6 cycles -> RAM[51..75] match the reference model; alu_a and alu_b stable while alu_valid=1 and alu_done=0.
- Illegal size: RAM[0]=0, then RAM[0]=6 -> done with error=1 and no mem_we in either case; error clears on the next valid start.
- opcode=3'b111 with N=3 -> error=1; no ALU strobe; no writes.
- Reset asserted during the third ALU wait with N=3 -> all outputs 0 immediately; RAM[19..20] written, RAM[21..27] untouched; a new start afterwards completes normally.
- start held high continuously across two operations -> second op begins one cycle after done; start pulses during busy are ignored (no restart, no extra done).
